// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one 1-cycle sprite ROM among NUM_REQ pixel fetchers.
// Optional macro SPR_ROM_ARB_PRIO_EN gives requester 0 absolute priority over the round-robin.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SPR_W   = 126,
  parameter int SPR_H   = 60,
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 4,
  parameter int ID_W    = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*7-1:0]  req_x,
  input  logic [NUM_REQ*6-1:0]  req_y,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [DATA_W-1:0]     rom_data,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_oob
);

`ifdef SPR_ROM_ARB_PRIO_EN
  localparam logic [ID_W-1:0] PTR_RST = ID_W'(1);
`else
  localparam logic [ID_W-1:0] PTR_RST = '0;
`endif

  logic            arb_en;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_nxt;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_any;
  logic            grant;
  logic [ID_W:0]   cand;
  logic [6:0]      sel_x;
  logic [5:0]      sel_y;
  logic            sel_oob;

  logic            s1_valid;
  logic            s1_oob;
  logic [ID_W-1:0] s1_id;
  logic            s2_valid;
  logic            s2_oob;
  logic [ID_W-1:0] s2_id;

  // Search from ptr upward with wrap; the first asserted request wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
`ifdef SPR_ROM_ARB_PRIO_EN
    if (req[0]) gnt_any = 1'b1;
    for (int k = 0; k < NUM_REQ - 1; k++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ - 1);
      if (!gnt_any && req[cand[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[ID_W-1:0];
      end
    end
    if (gnt_idx == '0)
      ptr_nxt = ptr;
    else if (gnt_idx == ID_W'(NUM_REQ - 1))
      ptr_nxt = ID_W'(1);
    else
      ptr_nxt = gnt_idx + ID_W'(1);
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!gnt_any && req[cand[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[ID_W-1:0];
      end
    end
    if (gnt_idx == ID_W'(NUM_REQ - 1))
      ptr_nxt = '0;
    else
      ptr_nxt = gnt_idx + ID_W'(1);
`endif
  end

  // Grants stay off until the first edge after reset release.
  assign grant = arb_en && gnt_any;

  always_comb begin
    gnt = '0;
    if (grant) gnt[gnt_idx] = 1'b1;
  end

  assign sel_x   = req_x[7*gnt_idx +: 7];
  assign sel_y   = req_y[6*gnt_idx +: 6];
  assign sel_oob = (32'(sel_x) >= SPR_W) || (32'(sel_y) >= SPR_H);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      arb_en   <= 1'b0;
      ptr      <= PTR_RST;
      rom_addr <= '0;
      s1_valid <= 1'b0;
      s1_oob   <= 1'b0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      s2_oob   <= 1'b0;
      s2_id    <= '0;
    end else begin
      arb_en   <= 1'b1;
      s1_valid <= grant;
      s2_valid <= s1_valid;
      s2_oob   <= s1_oob;
      s2_id    <= s1_id;
      if (grant) begin
        ptr      <= ptr_nxt;
        s1_id    <= gnt_idx;
        s1_oob   <= sel_oob;
        rom_addr <= sel_oob ? '0 : ADDR_W'(32'(sel_y) * 32'(SPR_W) + 32'(sel_x));
      end
    end
  end

  assign rsp_valid = s2_valid;
  assign rsp_id    = s2_valid ? s2_id : '0;
  assign rsp_oob   = s2_valid && s2_oob;
  assign rsp_data  = (s2_valid && !s2_oob) ? rom_data : '0;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: vector table, corner sequences, random traffic vs reference model.
// Honours SPR_ROM_ARB_PRIO_EN in the reference model and the priority sequence.
module tb_sprite_rom_arbiter;
  localparam int NR = 4;

  logic            Clk = 1'b0;
  logic            Reset;
  logic [NR-1:0]   req;
  logic [NR*7-1:0] req_x;
  logic [NR*6-1:0] req_y;
  logic [NR-1:0]   gnt;
  logic [12:0]     rom_addr;
  logic [3:0]      rom_data;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [3:0]      rsp_data;
  logic            rsp_oob;

  int errors = 0;
  int checks = 0;

  logic [3:0] rom_mem [0:8191];
  logic [NR-1:0] seen_gnt;

  // Reference model state: pending responses one and two cycles away.
  int m_ptr;
  bit m_en;
  int m_addr;
  bit s1_v, s2_v;
  int s1_id, s2_id, s1_addr, s2_addr;
  bit s1_oob, s2_oob;

  typedef struct {
    int id;
    int x;
    int y;
    int exp_addr;
    bit exp_oob;
  } vec_t;
  vec_t vecs [6];

  sprite_rom_arbiter dut (
    .Clk(Clk), .Reset(Reset), .req(req), .req_x(req_x), .req_y(req_y),
    .gnt(gnt), .rom_addr(rom_addr), .rom_data(rom_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_oob(rsp_oob)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) rom_data <= rom_mem[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_xy(input int i, input int x, input int y);
    req_x[7*i +: 7] = 7'(x);
    req_y[6*i +: 6] = 6'(y);
  endtask

  task automatic model_reset();
`ifdef SPR_ROM_ARB_PRIO_EN
    m_ptr = 1;
`else
    m_ptr = 0;
`endif
    m_en = 0; m_addr = 0; s1_v = 0; s2_v = 0;
  endtask

  function automatic int model_grant();
    int c;
    if (!m_en) return -1;
`ifdef SPR_ROM_ARB_PRIO_EN
    if (req[0]) return 0;
    for (int k = 0; k < NR - 1; k++) begin
      c = 1 + (m_ptr - 1 + k) % (NR - 1);
      if (req[c]) return c;
    end
`else
    for (int k = 0; k < NR; k++) begin
      c = (m_ptr + k) % NR;
      if (req[c]) return c;
    end
`endif
    return -1;
  endfunction

  // Compare every output to the model, then advance the model across the coming edge.
  task automatic check_step();
    int g, x, y, a;
    bit oob;
    logic [NR-1:0] eg;
    g = model_grant();
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    seen_gnt = gnt;
    chk("gnt", gnt, eg);
    chk("rom_addr", rom_addr, m_addr);
    chk("rsp_valid", rsp_valid, s2_v);
    chk("rsp_id", rsp_id, s2_v ? s2_id : 0);
    chk("rsp_oob", rsp_oob, s2_v && s2_oob);
    chk("rsp_data", rsp_data, (s2_v && !s2_oob) ? rom_mem[s2_addr] : 0);
    s2_v = s1_v; s2_id = s1_id; s2_oob = s1_oob; s2_addr = s1_addr;
    s1_v = 0;
    if (g >= 0) begin
      x = int'(req_x[7*g +: 7]);
      y = int'(req_y[6*g +: 6]);
      oob = (x >= 126) || (y >= 60);
      a = oob ? 0 : y * 126 + x;
      s1_v = 1; s1_id = g; s1_oob = oob; s1_addr = a; m_addr = a;
`ifdef SPR_ROM_ARB_PRIO_EN
      if (g != 0) m_ptr = (g == NR - 1) ? 1 : g + 1;
`else
      m_ptr = (g + 1) % NR;
`endif
    end
    m_en = !Reset;
  endtask

  task automatic at_neg();
    @(negedge Clk);
    check_step();
  endtask

  task automatic to_pos();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) rom_mem[i] = 4'($urandom);
    rom_mem[0] = 4'hA;
    vecs[0] = '{0, 5, 2, 257, 1'b0};
    vecs[1] = '{2, 125, 59, 7559, 1'b0};
    vecs[2] = '{1, 126, 0, 0, 1'b1};
    vecs[3] = '{1, 0, 60, 0, 1'b1};
    vecs[4] = '{3, 10, 10, 1270, 1'b0};
    vecs[5] = '{1, 0, 0, 0, 1'b0};

    Reset = 1'b1; req = '0; req_x = '0; req_y = '0; seen_gnt = '0;
    model_reset();
    at_neg(); to_pos();
    at_neg(); to_pos();
    Reset = 1'b0;
    at_neg(); to_pos();

    // Single-request vectors: grant, address one cycle later, response two cycles later.
    foreach (vecs[v]) begin
      req = '0; req[vecs[v].id] = 1'b1;
      set_xy(vecs[v].id, vecs[v].x, vecs[v].y);
      at_neg();
      chk("vec_gnt", gnt, 32'(1) << vecs[v].id);
      to_pos();
      req = '0;
      at_neg();
      chk("vec_addr", rom_addr, vecs[v].exp_addr);
      to_pos();
      at_neg();
      chk("vec_valid", rsp_valid, 1);
      chk("vec_id", rsp_id, vecs[v].id);
      chk("vec_oob", rsp_oob, vecs[v].exp_oob);
      chk("vec_data", rsp_data, vecs[v].exp_oob ? 0 : rom_mem[vecs[v].exp_addr]);
      to_pos();
    end

    // Reset in the cycle after a grant drops that request and restarts the pointer.
    req = 4'b0100; set_xy(2, 7, 3);
    at_neg();
    chk("pre_rst_gnt", gnt, 4'b0100);
    to_pos();
    req = '0; Reset = 1'b1; model_reset();
    at_neg(); to_pos();
    Reset = 1'b0;
    req = 4'b1010; set_xy(1, 1, 1); set_xy(3, 3, 3);
    at_neg();
    chk("rel_gnt_off", gnt, 0);
    to_pos();
    at_neg();
    chk("post_rst_gnt", gnt, 4'b0010);
    to_pos();
    req[1] = 1'b0;
    at_neg();
    chk("post_rst_gnt3", gnt, 4'b1000);
    to_pos();
    req = '0;
    for (int k = 0; k < 3; k++) begin at_neg(); to_pos(); end

    // All four held: rotating grants, responses two cycles later in the same order.
    for (int i = 0; i < NR; i++) set_xy(i, i * 10, i);
    for (int k = 0; k < 10; k++) begin
      req = (k < 8) ? 4'hF : 4'h0;
      at_neg();
`ifndef SPR_ROM_ARB_PRIO_EN
      if (k < 8) chk("rr_gnt", gnt, 32'(1) << (k % 4));
      if (k >= 2) begin
        chk("rr_valid", rsp_valid, 1);
        chk("rr_id", rsp_id, (k - 2) % 4);
      end
`endif
      to_pos();
    end

`ifdef SPR_ROM_ARB_PRIO_EN
    req = 4'b0101; set_xy(0, 1, 1); set_xy(2, 2, 2);
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("prio_gnt0", gnt, 4'b0001);
      to_pos();
    end
    req[0] = 1'b0;
    at_neg();
    chk("prio_gnt2", gnt, 4'b0100);
    to_pos();
`endif

    // Random traffic: each requester holds until granted, then may re-request with new coordinates.
    req = '0; seen_gnt = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req[i] || seen_gnt[i]) begin
          if ($urandom_range(0, 2) != 0) begin
            req[i] = 1'b1;
            set_xy(i, $urandom_range(0, 127), $urandom_range(0, 63));
          end else begin
            req[i] = 1'b0;
          end
        end
      end
      at_neg(); to_pos();
    end
    req = '0;
    for (int k = 0; k < 3; k++) begin at_neg(); to_pos(); end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
